driver_keys: RTL and testbench

//  Memory-mapped responder for the four DE1 push-buttons (key[3:0], active-low) on the DLX data bus.

---
 rtl/driver_keys.sv | 152 +++++++++++++++
 tb/tb_driver_keys.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/driver_keys.sv
// Memory-mapped responder for the DE1 push-buttons: synchronise, debounce, latch press/release
// events in W1C registers, count presses and raise a maskable press interrupt.
module driver_keys #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NKEYS           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key,
  input  logic             chip_select,
  input  logic [31:0]      address,
  input  logic             write_enable,
  input  logic [31:0]      data_write,
  output logic [31:0]      data_read,
  output logic             press_irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] RegState   = 2'd0;
  localparam logic [1:0] RegPress   = 2'd1;
  localparam logic [1:0] RegRelease = 2'd2;
  localparam logic [1:0] RegCount   = 2'd3;

  logic [NKEYS-1:0] sync1_q, sync2_q;
  logic [NKEYS-1:0] state_q, state_d;
  logic [CntW-1:0]  cnt_q [NKEYS];
  logic [CntW-1:0]  cnt_d [NKEYS];
  logic [NKEYS-1:0] rise, fall;
  logic [NKEYS-1:0] key_pressed;

  logic [NKEYS-1:0] press_evt_q, press_evt_d;
  logic [NKEYS-1:0] release_evt_q, release_evt_d;
  logic [7:0]       press_cnt_q [NKEYS];
  logic [7:0]       press_cnt_d [NKEYS];
  logic [7:0]       irq_mask_q, irq_mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             press_irq_q, press_irq_d;

  logic       wr_en, rd_en;
  logic [1:0] reg_sel;
  logic       unused_bus;

  assign wr_en       = chip_select & write_enable;
  assign rd_en       = chip_select & ~write_enable;
  assign reg_sel     = address[3:2];
  assign key_pressed = ~sync2_q;
  assign unused_bus  = ^{address, data_write};

  // Debounce: a differing sample must persist DEBOUNCE_CYCLES edges before it is accepted.
  always_comb begin
    state_d = state_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = '0;
      if (key_pressed[i] != state_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          state_d[i] = key_pressed[i];
          rise[i]    = key_pressed[i];
          fall[i]    = ~key_pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Register writes; hardware set/increment takes priority over a same-cycle software clear.
  always_comb begin
    press_evt_d   = press_evt_q;
    release_evt_d = release_evt_q;
    irq_mask_d    = irq_mask_q;
    if (wr_en && reg_sel == RegState) begin
      irq_mask_d = data_write[15:8];
    end
    if (wr_en && reg_sel == RegPress) begin
      press_evt_d = press_evt_q & ~data_write[NKEYS-1:0];
    end
    if (wr_en && reg_sel == RegRelease) begin
      release_evt_d = release_evt_q & ~data_write[NKEYS-1:0];
    end
    press_evt_d   = press_evt_d | rise;
    release_evt_d = release_evt_d | fall;
    for (int i = 0; i < NKEYS; i++) begin
      if (wr_en && reg_sel == RegCount) begin
        press_cnt_d[i] = rise[i] ? 8'd1 : 8'd0;
      end else if (rise[i]) begin
        press_cnt_d[i] = press_cnt_q[i] + 8'd1;
      end else begin
        press_cnt_d[i] = press_cnt_q[i];
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_sel)
        RegState: begin
          rdata_d[15:8]      = irq_mask_q;
          rdata_d[NKEYS-1:0] = state_q;
        end
        RegPress:   rdata_d[NKEYS-1:0] = press_evt_q;
        RegRelease: rdata_d[NKEYS-1:0] = release_evt_q;
        RegCount: begin
          for (int i = 0; i < NKEYS && i < 4; i++) begin
            rdata_d[8*i +: 8] = press_cnt_q[i];
          end
        end
        default: rdata_d = '0;
      endcase
    end
  end

  assign press_irq_d = |(press_evt_q & irq_mask_q[NKEYS-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      state_q       <= '0;
      press_evt_q   <= '0;
      release_evt_q <= '0;
      irq_mask_q    <= '0;
      rdata_q       <= '0;
      press_irq_q   <= 1'b0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i]       <= '0;
        press_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= key;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      press_evt_q   <= press_evt_d;
      release_evt_q <= release_evt_d;
      irq_mask_q    <= irq_mask_d;
      rdata_q       <= rdata_d;
      press_irq_q   <= press_irq_d;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i]       <= cnt_d[i];
        press_cnt_q[i] <= press_cnt_d[i];
      end
    end
  end

  assign data_read = rdata_q;
  assign press_irq = press_irq_q;

endmodule

// File: tb/tb_driver_keys.sv
// Directed bench for driver_keys with a 4-cycle debounce window.
module tb_driver_keys;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key = 4'hF;
  logic        chip_select = 1'b0;
  logic [31:0] address = '0;
  logic        write_enable = 1'b0;
  logic [31:0] data_write = '0;
  logic [31:0] data_read;
  logic        press_irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  driver_keys #(
    .DEBOUNCE_CYCLES(4),
    .NKEYS          (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .chip_select (chip_select),
    .address     (address),
    .write_enable(write_enable),
    .data_write  (data_write),
    .data_read   (data_read),
    .press_irq   (press_irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    chip_select = 1'b1;
    write_enable = 1'b0;
    address = a;
    @(posedge clk);
    #1;
    d = data_read;
    chip_select = 1'b0;
    address = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    chip_select = 1'b1;
    write_enable = 1'b1;
    address = a;
    data_write = d;
    @(posedge clk);
    #1;
    chip_select = 1'b0;
    write_enable = 1'b0;
    address = '0;
    data_write = '0;
  endtask

  task automatic clear_all();
    bus_write(32'h4, 32'hF);
    bus_write(32'h8, 32'hF);
    bus_write(32'hC, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(32'(a * 4), rd);
      total++;
      if (rd !== 32'h0) begin
        bad++;
        $display("FAIL reset_read_%0d got=%h exp=%h", a * 4, rd, 32'h0);
      end
    end
    total++;
    if (press_irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq got=%b exp=0", press_irq);
    end
  endtask

  task automatic test_press_release();
    key[0] = 1'b0;
    tick(5);
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL state_before_accept got=%h exp=%h", rd, 32'h0);
    end
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL state_after_accept got=%h exp=%h", rd, 32'h1);
    end
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL press_evt_key0 got=%h exp=%h", rd, 32'h1);
    end
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL press_cnt_key0 got=%h exp=%h", rd, 32'h1);
    end
    key[0] = 1'b1;
    tick(8);
    bus_read(32'h8, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL release_evt_key0 got=%h exp=%h", rd, 32'h1);
    end
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL state_released got=%h exp=%h", rd, 32'h0);
    end
    clear_all();
  endtask

  task automatic test_bounce();
    key[1] = 1'b0;
    tick(3);
    key[1] = 1'b1;
    tick(10);
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL bounce_state got=%h exp=%h", rd, 32'h0);
    end
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL bounce_press_evt got=%h exp=%h", rd, 32'h0);
    end
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL bounce_count got=%h exp=%h", rd, 32'h0);
    end
  endtask

  task automatic test_w1c();
    key = 4'h0;
    tick(8);
    key = 4'hF;
    tick(8);
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'hF) begin
      bad++;
      $display("FAIL w1c_all_set got=%h exp=%h", rd, 32'hF);
    end
    bus_write(32'h4, 32'h5);
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'hA) begin
      bad++;
      $display("FAIL w1c_clear_5 got=%h exp=%h", rd, 32'hA);
    end
    // key2 acceptance lands on the same edge as the W1C write of bit2
    key[2] = 1'b0;
    tick(5);
    bus_write(32'h4, 32'h4);
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'hE) begin
      bad++;
      $display("FAIL w1c_set_wins got=%h exp=%h", rd, 32'hE);
    end
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h0102_0101) begin
      bad++;
      $display("FAIL w1c_counts got=%h exp=%h", rd, 32'h0102_0101);
    end
    key[2] = 1'b1;
    tick(8);
    // key0 acceptance lands on the same edge as the count clear
    key[0] = 1'b0;
    tick(5);
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h0000_0001) begin
      bad++;
      $display("FAIL cnt_clear_reload got=%h exp=%h", rd, 32'h0000_0001);
    end
    key[0] = 1'b1;
    tick(8);
    clear_all();
  endtask

  task automatic test_irq();
    bus_write(32'h0, 32'h0200);
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h0000_0200) begin
      bad++;
      $display("FAIL irq_mask_read got=%h exp=%h", rd, 32'h0000_0200);
    end
    key[1] = 1'b0;
    tick(6);
    total++;
    if (press_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got=%b exp=0", press_irq);
    end
    tick(1);
    total++;
    if (press_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_raised got=%b exp=1", press_irq);
    end
    bus_write(32'h4, 32'h2);
    total++;
    if (press_irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold_at_clear got=%b exp=1", press_irq);
    end
    tick(1);
    total++;
    if (press_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_cleared got=%b exp=0", press_irq);
    end
    key[0] = 1'b0;
    tick(10);
    total++;
    if (press_irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_masked_key0 got=%b exp=0", press_irq);
    end
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL irq_press_evt got=%h exp=%h", rd, 32'h1);
    end
    key = 4'hF;
    tick(8);
    bus_write(32'h0, 32'h0);
    clear_all();
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 255; n++) begin
      key[3] = 1'b0;
      tick(7);
      key[3] = 1'b1;
      tick(7);
    end
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'hFF00_0000) begin
      bad++;
      $display("FAIL wrap_255 got=%h exp=%h", rd, 32'hFF00_0000);
    end
    for (int n = 0; n < 2; n++) begin
      key[3] = 1'b0;
      tick(7);
      key[3] = 1'b1;
      tick(7);
      bus_read(32'hC, rd);
      total++;
      if (rd !== (n == 0 ? 32'h0000_0000 : 32'h0100_0000)) begin
        bad++;
        $display("FAIL wrap_step_%0d got=%h exp=%h", n, rd,
                 (n == 0 ? 32'h0000_0000 : 32'h0100_0000));
      end
    end
    bus_write(32'hC, 32'h1234_5678);
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL wrap_clear got=%h exp=%h", rd, 32'h0);
    end
    clear_all();
  endtask

  task automatic test_reset_mid();
    bus_write(32'h0, 32'h0100);
    key[0] = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_state got=%h exp=%h", rd, 32'h0);
    end
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_evt got=%h exp=%h", rd, 32'h0);
    end
    tick(8);
    bus_read(32'h4, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL rstmid_held_evt got=%h exp=%h", rd, 32'h1);
    end
    bus_read(32'hC, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL rstmid_held_cnt got=%h exp=%h", rd, 32'h1);
    end
    bus_read(32'h0, rd);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL rstmid_mask_cleared got=%h exp=%h", rd, 32'h1);
    end
    total++;
    if (press_irq !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_irq got=%b exp=0", press_irq);
    end
    key = 4'hF;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_w1c();
    test_irq();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
